// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit
// Brief    : Iterative HI/LO multiply/divide unit (radix-2 shift-add multiply,
//            restoring divide) with mthi/mtlo access and flush support.
// Revision : 1.0
// ============================================================================
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_opnd;     // multiplicand (mul) or divisor (div)
    logic [2*WIDTH-1:0]     r_acc;      // {partial hi, shifting lo} / {remainder, quotient}
    logic                   r_div;
    logic                   r_neg_lo;   // product or quotient must be negated
    logic                   r_neg_hi;   // remainder must be negated
    logic                   r_zero;
    logic                   r_done;
    logic                   r_dz;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;

    logic [WIDTH-1:0]       w_abs_a;
    logic [WIDTH-1:0]       w_abs_b;
    logic [WIDTH:0]         w_mul_sum;
    logic [2*WIDTH-1:0]     w_mul_next;
    logic [WIDTH:0]         w_rem_sh;
    logic [WIDTH:0]         w_diff;
    logic [2*WIDTH-1:0]     w_div_next;
    logic [WIDTH-1:0]       w_rem;
    logic [WIDTH-1:0]       w_quo;
    logic [2*WIDTH-1:0]     w_prod_neg;
    logic [WIDTH-1:0]       w_fix_hi;
    logic [WIDTH-1:0]       w_fix_lo;

    assign w_abs_a = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign w_abs_b = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // Shift-add: conditionally add the multiplicand into the upper half, then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: shift in the next dividend bit, keep the difference if non-negative.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_opnd};
    assign w_div_next = w_diff[WIDTH]
                        ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                        : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
    assign w_quo      = r_acc[WIDTH-1:0];
    assign w_prod_neg = -r_acc;

    always_comb begin
        w_fix_hi = w_rem;
        w_fix_lo = w_quo;
        if (r_div) begin
            if (r_neg_hi) w_fix_hi = -w_rem;
            if (r_neg_lo) w_fix_lo = -w_quo;
        end else if (r_neg_lo) begin
            w_fix_hi = w_prod_neg[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod_neg[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_div    <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            if (flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (mthi) r_hi <= wr_data;
                        if (mtlo) r_lo <= wr_data;
                        if (start) begin
                            r_div    <= op_div;
                            r_neg_lo <= op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            r_neg_hi <= op_signed & src_a[WIDTH-1];
                            r_cnt    <= '0;
                            if (op_div && (src_b == '0)) begin
                                r_zero  <= 1'b1;
                                r_state <= ST_FIX;
                            end else begin
                                r_zero  <= 1'b0;
                                r_opnd  <= op_div ? w_abs_b : w_abs_a;
                                r_acc   <= {{WIDTH{1'b0}}, (op_div ? w_abs_a : w_abs_b)};
                                r_state <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        r_acc <= r_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_last_step) r_state <= ST_FIX;
                    end
                    ST_FIX: begin
                        if (!r_zero) begin
                            r_hi <= w_fix_hi;
                            r_lo <= w_fix_lo;
                        end
                        r_done  <= 1'b1;
                        r_dz    <= r_zero;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width and the width of each of HI and LO.
REQ-002 The block SHALL have parameter CNT_W, default 6, giving the iteration counter width; CNT_W SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  requests a new multiply or divide.
REQ-007 op_div  input  1  operation select: 1 = divide, 0 = multiply; sampled with start.
REQ-008 op_signed  input  1  operand interpretation: 1 = two's complement, 0 = unsigned; sampled with start.
REQ-009 src_a  input  WIDTH  multiplicand or dividend.
REQ-010 src_b  input  WIDTH  multiplier or divisor.
REQ-011 mthi  input  1  write wr_data into HI.
REQ-012 mtlo  input  1  write wr_data into LO.
REQ-013 wr_data  input  WIDTH  data for mthi/mtlo.
REQ-014 flush  input  1  aborts any in-flight operation.
REQ-015 busy  output  1  high while the state is not IDLE; the pipeline stalls mfhi/mflo on it.
REQ-016 done  output  1  one-cycle pulse when HI/LO receive a result or a divide-by-zero is reported.
REQ-017 div_by_zero  output  1  one-cycle pulse, coincident with done, for a divide with src_b == 0.
REQ-018 hi  output  WIDTH  current HI register.
REQ-019 lo  output  WIDTH  current LO register.

Function
REQ-020 The block SHALL implement the states IDLE, CALC and FIX.
REQ-021 A start sampled in IDLE SHALL be accepted.
- If the operation is a divide with src_b == 0, the next state SHALL be FIX with the zero flag set.
- Otherwise the block SHALL latch the operand magnitudes (absolute values when op_signed) and the result-sign flags, clear the counter, and enter CALC.
REQ-022 CALC SHALL perform one radix-2 step per cycle.
- Multiply: shift-add.
- Divide: restoring.
- CALC lasts exactly WIDTH cycles, then enters FIX.
REQ-023 FIX SHALL last one cycle and then return to IDLE.
- It applies sign correction.
- It writes HI/LO on the FIX-to-IDLE edge; the zero flag suppresses this write.
- It asserts done, and div_by_zero when the zero flag is set.
REQ-024 Latency SHALL be WIDTH+2 cycles from the start edge to the done edge; a divide-by-zero completes in 2 cycles.
REQ-025 Multiply results SHALL be HI = upper WIDTH bits and LO = lower WIDTH bits of the full 2*WIDTH-bit product.
REQ-026 Divide results SHALL be LO = quotient, truncated toward zero, and HI = remainder, carrying the sign of the dividend.
REQ-027 A signed divide of the most negative value by -1 SHALL give LO = most negative value and HI = 0, with no flag raised.
REQ-028 start SHALL be ignored while busy.
REQ-029 mthi/mtlo SHALL be ignored while busy; in IDLE they SHALL update the register on the next edge.
REQ-030 If mthi/mtlo and start coincide in IDLE, the register write SHALL occur and the start SHALL be accepted.
REQ-031 flush SHALL take priority over start, mthi and mtlo.
- It forces IDLE on the next edge.
- It leaves HI/LO unchanged and suppresses done.
- A flush asserted in FIX SHALL also suppress the HI/LO write.
REQ-032 hi and lo SHALL be driven directly from registers, with no combinational path from the inputs.

Reset
REQ-033 On rst the block SHALL enter IDLE and clear HI, LO, the counter, the internal operand registers, busy, done and div_by_zero to 0.
REQ-034 rst SHALL override every other input, including during CALC or FIX; no done SHALL follow.

Verification
REQ-035 Unsigned multiply, WIDTH=32: 0xFFFFFFFF * 0xFFFFFFFF -> done on the 34th edge after start, HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 Signed divide: -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; signed multiply -3 * 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-037 Divide by zero: HI=0xAAAA0000, LO=0x5555 preloaded, then 10 / 0 -> done and div_by_zero on the 2nd edge, HI/LO unchanged, busy low after.
REQ-038 Signed overflow: 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, div_by_zero low.
REQ-039 Flush in CALC, cycle 10 -> busy low next edge, no done, HI/LO keep prior values; a start on the following cycle is accepted and completes normally.
REQ-040 Register access and reset:
- mthi 0x1234 in IDLE -> hi=0x1234 next edge.
- mtlo and start during busy -> ignored.
- rst in CALC -> IDLE, hi=lo=0.
